// File: rtl/can_rx_frame_fifo.sv
// can_rx_frame_fifo: receive-side stage after the CAN packet controller.
// Filters each received frame by ID/mask (and optionally IDE), stores accepted
// frames in a 2^AW-entry frame FIFO and serialises each stored payload as a
// byte stream with valid/ready handshake and per-frame sideband.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   rx_valid/id/ide/rtr/len/data  frame strobe and fields from packet controller
//   rx_ack                     ACK permission, high the cycle after an accepted frame
//   out_valid/ready/data/last/nodata  byte stream handshake
//   out_id/ide/rtr             sideband of the frame being emitted
//   fifo_count                 frames stored (not counting the output stage)
//   drop_cnt                   matching frames lost to a full FIFO (saturating)
module can_rx_frame_fifo #(
  parameter logic [28:0] FILTER_ID     = 29'h0,
  parameter logic [28:0] FILTER_MASK   = 29'h0,
  parameter logic        FILTER_IDE_EN = 1'b0,
  parameter logic        FILTER_IDE    = 1'b0,
  parameter int unsigned AW            = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [28:0]   rx_id,
  input  logic          rx_ide,
  input  logic          rx_rtr,
  input  logic [3:0]    rx_len,
  input  logic [63:0]   rx_data,
  output logic          rx_ack,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          out_nodata,
  output logic [28:0]   out_id,
  output logic          out_ide,
  output logic          out_rtr,
  output logic [AW:0]   fifo_count,
  output logic [15:0]   drop_cnt
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  n;
    logic [63:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic [63:0]     shreg;
  logic [3:0]      rem;

  logic [3:0]      rx_n;
  logic            match;
  logic            full;
  logic            empty;
  logic            push;
  logic            drop;
  logic            pop;
  logic            hs;
  entry_t          head;
  logic [6:0]      shamt;
  logic [63:0]     head_bytes;

  // Byte count of the incoming frame: RTR carries none, DLC above 8 means 8.
  always_comb begin
    rx_n = 4'd0;
    if (!rx_rtr) rx_n = (rx_len > 4'd8) ? 4'd8 : rx_len;
  end

  // Acceptance filter and push/drop decision; full uses the pre-pop count.
  always_comb begin
    match = (((rx_id ^ FILTER_ID) & FILTER_MASK) == 29'd0) &&
            (!FILTER_IDE_EN || (rx_ide == FILTER_IDE));
    full  = (fifo_count == CW'(DEPTH));
    empty = (fifo_count == CW'(0));
    push  = rx_valid && match && !full;
    drop  = rx_valid && match && full;
    hs    = out_valid && out_ready;
  end

  // Head entry left-aligned so its first payload byte sits in bits [63:56].
  always_comb begin
    head       = mem[rd_ptr];
    shamt      = {4'd8 - head.n, 3'b000};
    head_bytes = (head.n == 4'd0) ? 64'd0 : (head.data << shamt);
  end

  // Output-stage next state and pop; the next frame is popped on the
  // last-beat handshake so queued frames stream without a bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && out_last) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: rx_id, ide: rx_ide, rtr: rx_rtr, n: rx_n, data: rx_data};
  end

  // FIFO bookkeeping, ACK and drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_ack     <= 1'b0;
      drop_cnt   <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      rx_ack     <= push;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // State register and byte serialiser.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      out_valid  <= 1'b0;
      shreg      <= 64'd0;
      rem        <= 4'd0;
      out_last   <= 1'b0;
      out_nodata <= 1'b0;
      out_id     <= 29'd0;
      out_ide    <= 1'b0;
      out_rtr    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        out_valid  <= 1'b1;
        shreg      <= head_bytes;
        rem        <= head.n;
        out_last   <= (head.n <= 4'd1);
        out_nodata <= (head.n == 4'd0);
        out_id     <= head.id;
        out_ide    <= head.ide;
        out_rtr    <= head.rtr;
      end else if (hs) begin
        if (out_last) begin
          out_valid <= 1'b0;
        end else begin
          shreg    <= shreg << 8;
          rem      <= rem - 4'd1;
          out_last <= (rem == 4'd2);
        end
      end
    end
  end

  assign out_data = shreg[63:56];

endmodule
